// File: rtl/kyber_decrypt_core.sv
// Baby-Kyber (q=17, n=4, k=2) decryption: w = s^T.u accumulated one negacyclic
// multiply-accumulate per cycle, then d = v - w decoded into a 4-bit message.
module kyber_decrypt_core #(
  parameter int Q = 17,
  parameter int N = 4,
  parameter int K = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] s [K][N],
  input  logic signed [31:0] u [K][N],
  input  logic signed [31:0] v [N],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        message,
  output logic               busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [9:0] Q10       = 10'(Q);
  localparam logic [9:0] WRAP_BIAS = 10'(Q * (Q - 1));
  localparam logic [5:0] Q6        = 6'(Q);

  // Signed remainder keeps the dividend's sign, so fold negatives back into [0,Q-1].
  function automatic logic [4:0] normQ(input logic signed [31:0] x);
    logic signed [31:0] rem;
    rem = x % Q;
    if (rem < 0) rem = rem + Q;
    return 5'(rem);
  endfunction

  logic [2:0] r_state;
  logic [4:0] r_cnt;
  logic [4:0] r_s [K][N];
  logic [4:0] r_u [K][N];
  logic [4:0] r_v [N];
  logic [4:0] r_w [N];
  logic [3:0] r_msg;

  logic       w_p;
  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [1:0] w_c;
  logic [2:0] w_sum;
  logic [8:0] w_prod;
  logic [9:0] w_acc;
  logic [4:0] w_wNext;
  logic [5:0] w_d [N];
  logic [3:0] w_bits;

  assign w_p    = r_cnt[4];
  assign w_a    = r_cnt[3:2];
  assign w_b    = r_cnt[1:0];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_c    = w_sum[1:0];
  assign w_prod = {4'b0, r_s[w_p][w_a]} * {4'b0, r_u[w_p][w_b]};

  // x^4 = -1: terms landing at degree >= 4 are subtracted, biased by Q*(Q-1) to stay unsigned.
  assign w_acc   = w_sum[2] ? ({5'b0, r_w[w_c]} + WRAP_BIAS - {1'b0, w_prod})
                            : ({5'b0, r_w[w_c]} + {1'b0, w_prod});
  assign w_wNext = 5'(w_acc % Q10);

  // Coefficient i carries message bit 3-i; values near q/2 decode as 1.
  always_comb begin
    w_bits = 4'b0;
    for (int i = 0; i < N; i++) begin
      w_d[i] = ({1'b0, r_v[i]} + Q6 - {1'b0, r_w[i]}) % Q6;
      w_bits[N-1-i] = (w_d[i] >= 6'd5) && (w_d[i] <= 6'd12);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_msg   <= 4'd0;
      for (int i = 0; i < N; i++) begin
        r_v[i] <= 5'd0;
        r_w[i] <= 5'd0;
        for (int p = 0; p < K; p++) begin
          r_s[p][i] <= 5'd0;
          r_u[p][i] <= 5'd0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              r_v[i] <= normQ(v[i]);
              r_w[i] <= 5'd0;
              for (int p = 0; p < K; p++) begin
                r_s[p][i] <= normQ(s[p][i]);
                r_u[p][i] <= normQ(u[p][i]);
              end
            end
            r_cnt   <= 5'd0;
            r_state <= S_LOAD;
          end
        end
        // Single settle slot so accept-to-valid latency is a fixed 34 cycles.
        S_LOAD: r_state <= S_MAC;
        S_MAC: begin
          r_w[w_c] <= w_wNext;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_msg   <= w_bits;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_LOAD) || (r_state == S_MAC) || (r_state == S_FINAL);
  assign message   = {28'b0, r_msg};

endmodule

// File: tb/tb_kyber_decrypt_core.sv
// Self-checking bench for kyber_decrypt_core: directed cases, random operands against a
// ring-arithmetic reference model, backpressure, mid-operation reset and encrypt/decrypt round trips.
module tb_kyber_decrypt_core;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] tbS [2][4];
  logic signed [31:0] tbU [2][4];
  logic signed [31:0] tbV [4];
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        message;
  logic               busy;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  kyber_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (tbS),
    .u         (tbU),
    .v         (tbV),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .message   (message),
    .busy      (busy)
  );

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int modq(input int x);
    return ((x % 17) + 17) % 17;
  endfunction

  // Reference decryption straight from the ring definition: w = sum_p s_p * u_p mod (x^4+1).
  function automatic logic [3:0] modelDecrypt();
    int w [4];
    int d;
    logic [3:0] m;
    for (int i = 0; i < 4; i++) w[i] = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          if (a + b < 4) w[a+b]   += modq(int'(tbS[p][a])) * modq(int'(tbU[p][b]));
          else           w[a+b-4] -= modq(int'(tbS[p][a])) * modq(int'(tbU[p][b]));
        end
    m = 4'b0;
    for (int i = 0; i < 4; i++) begin
      d = modq(int'(tbV[i]) - w[i]);
      m[3-i] = (d >= 5) && (d <= 12);
    end
    return m;
  endfunction

  task automatic clearOperands();
    for (int i = 0; i < 4; i++) begin
      tbV[i] = 0;
      for (int p = 0; p < 2; p++) begin
        tbS[p][i] = 0;
        tbU[p][i] = 0;
      end
    end
  endtask

  task automatic randomOperands(input bit wide);
    for (int i = 0; i < 4; i++) begin
      tbV[i] = wide ? $urandom() : int'($urandom_range(80)) - 40;
      for (int p = 0; p < 2; p++) begin
        tbS[p][i] = wide ? $urandom() : int'($urandom_range(80)) - 40;
        tbU[p][i] = wide ? $urandom() : int'($urandom_range(80)) - 40;
      end
    end
  endtask

  // One full transaction: accept, latency count, result check, optional hold, handshake.
  task automatic applyStimulus(input logic [3:0] expMsg, input string tag, input int holdCycles);
    int cycles;
    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
    randomOperands(1'b1);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'd34);
    checkOutput({tag, " message"}, message, {28'b0, expMsg});
    for (int k = 0; k < holdCycles; k++) begin
      in_valid = (k == 3);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " held message"}, message, {28'b0, expMsg});
      checkOutput({tag, " held out_valid"}, 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    if (holdCycles > 0) checkOutput({tag, " in_ready while held"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
  endtask

  // Encrypt a message with small noise, retrying until the noise stays inside the decode window.
  task automatic roundTrip(input logic [3:0] m);
    int A [2][2][4];
    int sk [2][4];
    int e [2][4];
    int t [2][4];
    int r [2][4];
    int e1 [2][4];
    int e2 [4];
    int uu [2][4];
    int vv [4];
    int prod;
    int tries;
    logic [3:0] got;
    tries = 0;
    do begin
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 2; j++) A[i][j][c] = int'($urandom_range(16));
          sk[i][c] = int'($urandom_range(2)) - 1;
          e[i][c]  = int'($urandom_range(2)) - 1;
          r[i][c]  = int'($urandom_range(2)) - 1;
          e1[i][c] = int'($urandom_range(2)) - 1;
        end
      for (int c = 0; c < 4; c++) e2[c] = int'($urandom_range(2)) - 1;
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 4; c++) begin
          t[i][c]  = e[i][c];
          uu[i][c] = e1[i][c];
        end
      end
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
              prod = A[i][j][a] * sk[j][b];
              if (a + b < 4) t[i][a+b] += prod; else t[i][a+b-4] -= prod;
              prod = A[i][j][a] * r[i][b];
              if (a + b < 4) uu[j][a+b] += prod; else uu[j][a+b-4] -= prod;
            end
      for (int c = 0; c < 4; c++) vv[c] = e2[c] + (m[3-c] ? 9 : 0);
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++) begin
            prod = t[i][a] * r[i][b];
            if (a + b < 4) vv[a+b] += prod; else vv[a+b-4] -= prod;
          end
      for (int c = 0; c < 4; c++) begin
        tbV[c] = vv[c];
        for (int p = 0; p < 2; p++) begin
          tbS[p][c] = sk[p][c];
          tbU[p][c] = uu[p][c];
        end
      end
      tries++;
      got = modelDecrypt();
    end while (got != m && tries < 50);
    applyStimulus(m, "roundTrip", 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] expMsg;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clearOperands();
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset message", message, 32'd0);
    rst_n = 1'b1;

    // Zero key: w = 0, so d = v.
    clearOperands();
    for (int i = 0; i < 4; i++) begin
      tbU[0][i] = int'($urandom_range(100));
      tbU[1][i] = int'($urandom_range(100));
    end
    tbV[0] = 8;
    applyStimulus(4'h8, "zeroKey", 0);

    // Single non-wrapping product lands in w[3].
    clearOperands();
    tbS[0][0] = 1;
    tbU[0][3] = 1;
    tbV[3]    = 10;
    applyStimulus(4'h1, "simpleProduct", 0);

    // x * x^3 wraps to -1 in w[0]; v[0] = -9 normalises to 8.
    clearOperands();
    tbS[0][1] = 1;
    tbU[0][3] = 1;
    tbV[0]    = -9;
    applyStimulus(4'h8, "negacyclicWrap", 0);

    // Reset during MAC cycle 15 discards the in-flight result (message above is non-zero).
    randomOperands(1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midReset message", message, 32'd0);
    checkOutput("midReset in_ready", 32'(in_ready), 32'd1);
    checkOutput("midReset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    randomOperands(1'b0);
    expMsg = modelDecrypt();
    applyStimulus(expMsg, "afterReset", 0);

    // Random operands, both small signed and full 32-bit range.
    for (int n = 0; n < 8; n++) begin
      randomOperands(n[0]);
      expMsg = modelDecrypt();
      applyStimulus(expMsg, "random", 0);
    end

    // Backpressure with an ignored in_valid pulse while the result is held.
    randomOperands(1'b0);
    expMsg = modelDecrypt();
    applyStimulus(expMsg, "backpressure", 10);

    for (int m = 0; m < 16; m++) roundTrip(4'(m));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
